// File: rtl/tap_window_sequencer_if.sv
// rtl/tap_window_sequencer_if.sv - sample/sum handshakes and delay-line control bundle for tap_window_sequencer
interface tap_window_sequencer_if #(
    parameter int DW = 4
);
    localparam int SUM_W = DW + 3;

    logic             in_valid;
    logic [DW-1:0]    in_data;
    logic             in_ready;
    logic [DW-1:0]    dl_din;
    logic             dl_ce;
    logic [2:0]       dl_sel;
    logic [DW-1:0]    dl_tap;
    logic             sum_valid;
    logic             sum_ready;
    logic [SUM_W-1:0] sum_data;
    logic             win_full;

    // Environment side: sample source, delay line tap output, sum consumer
    modport master (
        output in_valid, in_data, dl_tap, sum_ready,
        input  in_ready, dl_din, dl_ce, dl_sel, sum_valid, sum_data, win_full
    );

    // Sequencer side
    modport slave (
        input  in_valid, in_data, dl_tap, sum_ready,
        output in_ready, dl_din, dl_ce, dl_sel, sum_valid, sum_data, win_full
    );
endinterface

// File: rtl/tap_window_sequencer.sv
// rtl/tap_window_sequencer.sv - shifts one sample into the 8-tap delay line, scans all taps and emits the window sum
// Optional FILL_GATE_EN: suppress sum_valid until 8 samples have filled the window.
module tap_window_sequencer #(
    parameter int DW = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    tap_window_sequencer_if.slave bus
);
    localparam int SUM_W = DW + 3;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_SCAN  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [3:0] FILL_MAX = 4'd8;

    logic [1:0]       state_q, state_d;
    logic [DW-1:0]    din_q, din_d;
    logic [2:0]       scan_q, scan_d;
    logic [SUM_W-1:0] acc_q, acc_d;
    logic [SUM_W-1:0] sum_q, sum_d;
    logic             sum_valid_q, sum_valid_d;
    logic [3:0]       fill_q, fill_d;

    always_comb begin
        state_d     = state_q;
        din_d       = din_q;
        scan_d      = scan_q;
        acc_d       = acc_q;
        sum_d       = sum_q;
        sum_valid_d = sum_valid_q;
        fill_d      = fill_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    din_d   = bus.in_data;
                    fill_d  = (fill_q == FILL_MAX) ? fill_q : fill_q + 4'd1;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                acc_d   = '0;
                scan_d  = 3'd0;
                state_d = S_SCAN;
            end
            S_SCAN: begin
                acc_d  = acc_q + SUM_W'(bus.dl_tap);
                scan_d = scan_q + 3'd1;
                if (scan_q == 3'd7) begin
`ifdef FILL_GATE_EN
                    // Partial windows still refresh sum_data but never raise sum_valid
                    if (fill_q != FILL_MAX) begin
                        sum_d   = acc_d;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DONE;
                    end
`else
                    state_d = S_DONE;
`endif
                end
            end
            default: begin
                // First DONE cycle loads the result; sum_ready only matters once it is valid
                if (!sum_valid_q) begin
                    sum_d       = acc_q;
                    sum_valid_d = 1'b1;
                end else if (bus.sum_ready) begin
                    sum_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= S_IDLE;
            din_q       <= '0;
            scan_q      <= 3'd0;
            acc_q       <= '0;
            sum_q       <= '0;
            sum_valid_q <= 1'b0;
            fill_q      <= 4'd0;
        end else begin
            state_q     <= state_d;
            din_q       <= din_d;
            scan_q      <= scan_d;
            acc_q       <= acc_d;
            sum_q       <= sum_d;
            sum_valid_q <= sum_valid_d;
            fill_q      <= fill_d;
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.dl_din    = din_q;
    assign bus.dl_ce     = (state_q == S_SHIFT);
    assign bus.dl_sel    = (state_q == S_SCAN) ? scan_q : 3'd0;
    assign bus.sum_valid = sum_valid_q;
    assign bus.sum_data  = sum_q;
    assign bus.win_full  = (fill_q == FILL_MAX);

endmodule
